// File: rtl/mat_mult_seq.sv
// Sequential NxN unsigned matrix multiplier: one multiply-accumulate per cycle,
// result elements written row-major as each dot product completes.
module mat_mult_seq #(
    parameter int N   = 3,
    parameter int DW  = 8,
    parameter int RW  = 8,
    parameter int SAT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*N*DW-1:0]   a,
    input  logic [N*N*DW-1:0]   b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*N*RW-1:0]   res,
    output logic                ovf,
    output logic                busy
);
    localparam int AW = 2*DW + $clog2(N);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [N*N*DW-1:0]   r_a;
    logic [N*N*DW-1:0]   r_b;
    logic [AW-1:0]       r_acc;
    logic [IW-1:0]       r_i;
    logic [IW-1:0]       r_j;
    logic [IW-1:0]       r_k;
    logic [N*N*RW-1:0]   r_res;
    logic                r_ovf;

    logic [DW-1:0]       w_a_el [N][N];
    logic [DW-1:0]       w_b_el [N][N];
    logic [2*DW-1:0]     w_prod;
    logic [AW-1:0]       w_sum;
    logic                w_over;
    logic [RW-1:0]       w_elem;
    logic                w_hs_in;
    logic                w_last_k;
    logic                w_last_all;

    // Element (0,0) sits in the most significant slot of the flat operand.
    always_comb begin
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                w_a_el[r][c] = r_a[((N*N-1)-(r*N+c))*DW +: DW];
                w_b_el[r][c] = r_b[((N*N-1)-(r*N+c))*DW +: DW];
            end
        end
    end

    assign w_prod     = w_a_el[r_i][r_k] * w_b_el[r_k][r_j];
    assign w_sum      = r_acc + AW'(w_prod);
    assign w_over     = (w_sum >> RW) != '0;
    assign w_elem     = ((SAT != 0) && w_over) ? '1 : w_sum[RW-1:0];
    assign w_hs_in    = in_valid && (r_state == S_IDLE);
    assign w_last_k   = (r_k == IW'(N-1));
    assign w_last_all = w_last_k && (r_i == IW'(N-1)) && (r_j == IW'(N-1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)   w_next = S_CALC;
            S_CALC:  if (w_last_all) w_next = S_DONE;
            S_DONE:  if (out_ready)  w_next = S_IDLE;
            default:                 w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        busy      = (r_state == S_CALC) || (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_i   <= '0;
            r_j   <= '0;
            r_k   <= '0;
            r_res <= '0;
            r_ovf <= 1'b0;
        end else if (w_hs_in) begin
            r_a   <= a;
            r_b   <= b;
            r_acc <= '0;
            r_i   <= '0;
            r_j   <= '0;
            r_k   <= '0;
            r_ovf <= 1'b0;
        end else if (r_state == S_CALC) begin
            if (!w_last_k) begin
                r_acc <= w_sum;
                r_k   <= r_k + 1'b1;
            end else begin
                r_acc <= '0;
                r_k   <= '0;
                if (w_over) r_ovf <= 1'b1;
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        if (r_i == IW'(r) && r_j == IW'(c))
                            r_res[((N*N-1)-(r*N+c))*RW +: RW] <= w_elem;
                    end
                end
                // Column index wraps into the next row; both return to 0 after the last element.
                if (r_j == IW'(N-1)) begin
                    r_j <= '0;
                    r_i <= (r_i == IW'(N-1)) ? '0 : r_i + 1'b1;
                end else begin
                    r_j <= r_j + 1'b1;
                end
            end
        end
    end

    assign res = r_res;
    assign ovf = r_ovf;
endmodule

// File: doc/mat_mult_seq.md
MAT_MULT_SEQ -- requirements
Module: mat_mult_seq

Parameters
REQ-001 N, default 3: matrix dimension; square NxN operands, N >= 2.
REQ-002 DW, default 8: unsigned operand element width.
REQ-003 RW, default 8: result element width, 1 <= RW <= AW.
REQ-004 SAT, default 0: result mode; 0 = wrap (keep low RW bits), 1 = unsigned saturate.
REQ-005 AW (derived, not overridable) SHALL be 2*DW + clog2(N): the internal accumulator width.

Interface
REQ-006 clk  input  1  single clock; all logic on the rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 in_valid  input  1  A/B operand pair presented.
REQ-009 in_ready  output  1  block can accept an operand pair.
REQ-010 a  input  N*N*DW  matrix A, row-major, element (0,0) in the most significant DW bits.
REQ-011 b  input  N*N*DW  matrix B, same packing as a.
REQ-012 out_valid  output  1  res holds a completed product.
REQ-013 out_ready  input  1  consumer accepts res.
REQ-014 res  output  N*N*RW  product A*B, row-major, element (0,0) in the most significant RW bits.
REQ-015 ovf  output  1  at least one element of res exceeded 2^RW-1 before wrap/saturation.
REQ-016 busy  output  1  high in CALC or DONE.

Function
REQ-017 FSM states SHALL be IDLE, CALC, DONE; the reset state is IDLE.
REQ-018 in_ready SHALL be 1 only in IDLE, and in_valid SHALL be ignored in every other state.
REQ-019 On a handshake (in_valid & in_ready), the block SHALL register a and b, clear the accumulator and ovf, set indices i=j=k=0, and enter CALC.
REQ-020 In CALC, each cycle SHALL perform exactly one MAC: acc += A[i][k]*B[k][j], computed at full AW width.
REQ-021 When k==N-1, the block SHALL write element (i,j) of res from acc + product, clear acc, reset k to 0, and advance j; j wraps to 0 with i incrementing.
REQ-022 The write of element (i,j) SHALL use: SAT=0 -> low RW bits; SAT=1 -> all ones when the value exceeds 2^RW-1.
REQ-023 The ovf flag SHALL be set (sticky) whenever a written element value exceeds 2^RW-1, in both modes.
REQ-024 After the MAC at i=j=k=N-1, the FSM SHALL enter DONE.
REQ-025 Latency: with the handshake at edge E0, out_valid SHALL be 1 after edge E(N^3); for N=3 this is 27 cycles.
REQ-026 In DONE, out_valid SHALL be 1 and res and ovf SHALL be held stable until out_ready=1.
REQ-027 On the edge where out_valid & out_ready, the FSM SHALL return to IDLE: out_valid=0 and in_ready=1 on the next cycle.
REQ-028 res and ovf SHALL hold their last values in IDLE, and SHALL be overwritten element-by-element during the next CALC.
REQ-029 Operations SHALL NOT overlap: a new pair is accepted no earlier than the cycle after the output handshake.

Reset
REQ-030 When rst=1 at an edge, the FSM SHALL go to IDLE from any state, including mid-CALC; the partial result is discarded.
REQ-031 Reset values SHALL be: out_valid=0, busy=0, ovf=0, res=0, acc=0, i=j=k=0; in_ready=1 in the cycle after reset is released.
REQ-032 rst SHALL take priority over any simultaneous input or output handshake.

Verification (N=3, DW=8, RW=8 unless stated)
REQ-033 A=identity, B=1..9 row-major -> res=1..9, ovf=0, out_valid 27 cycles after accept.
REQ-034 A and B all 16, SAT=0 -> every element 768 mod 256 = 0x00, ovf=1; with SAT=1 -> every element 0xFF, ovf=1.
REQ-035 out_ready held 0 for 10 cycles in DONE, with new in_valid pulsed -> res, out_valid and ovf unchanged; in_ready=0; new data not captured.
REQ-036 rst asserted 5 cycles into CALC -> next cycle: out_valid=0, busy=0, res=0; in_ready=1 after release; a fresh pair then computes correctly.
REQ-037 N=4, DW=16, RW=34, A and B all 0xFFFF -> every element 0x3FFF80004, ovf=0, latency 64 cycles.
REQ-038 Two pairs back-to-back with out_ready=1 -> second accepted exactly 1 cycle after the first output handshake; both results correct.
